// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking slot allocator.
package parking_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOpen = 1'b1
  } park_state_e;

  localparam int unsigned DefNumSlots  = 4;
  localparam int unsigned DefSlotW     = 2;
  localparam int unsigned DefGateCycles = 8;

endpackage

// File: rtl/park_free_encoder.sv
// Lowest-zero priority encoder over the occupancy vector.
module park_free_encoder
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DefNumSlots,
  parameter int unsigned SLOT_W    = DefSlotW
) (
  input  logic [NUM_SLOTS-1:0] occupancy_i,
  output logic [SLOT_W-1:0]    free_idx_o,
  output logic                 all_full_o
);

  // Scan high to low so the last hit (the lowest free index) wins.
  always_comb begin
    free_idx_o = '0;
    all_full_o = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy_i[i]) begin
        free_idx_o = SLOT_W'(i);
        all_full_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: entry/exit handshakes, lowest-free-slot allocation, timed barrier.
// Optional PARK_STATS_EN adds saturating accepted-entry and full-rejection counters.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = DefNumSlots,
  parameter int unsigned SLOT_W      = DefSlotW,
  parameter int unsigned GATE_CYCLES = DefGateCycles
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 entry_req,
  output logic                 entry_ack,
  output logic                 entry_full,
  output logic [SLOT_W-1:0]    entry_slot,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 exit_ack,
  output logic                 exit_err,
  output logic                 gate_open,
`ifdef PARK_STATS_EN
  output logic [7:0]           entry_count,
  output logic [7:0]           reject_count,
`endif
  output logic [NUM_SLOTS-1:0] occupancy
);

  localparam int unsigned CntW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned PadW = 1 << SLOT_W;

  park_state_e           state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]  occ_q, occ_d;
  logic                  entry_ack_q, entry_ack_d;
  logic                  entry_full_q, entry_full_d;
  logic [SLOT_W-1:0]     entry_slot_q, entry_slot_d;
  logic                  exit_ack_q, exit_ack_d;
  logic                  exit_err_q, exit_err_d;
  logic [SLOT_W-1:0]     free_idx;
  logic                  all_full;
  logic [PadW-1:0]       occ_pad;
  logic                  exit_hit;

  park_free_encoder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_free_encoder (
    .occupancy_i (occ_q),
    .free_idx_o  (free_idx),
    .all_full_o  (all_full)
  );

  // Zero padding makes out-of-range slot numbers read as unoccupied.
  assign occ_pad  = PadW'(occ_q);
  assign exit_hit = occ_pad[exit_slot];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    occ_d        = occ_q;
    entry_ack_d  = 1'b0;
    entry_full_d = 1'b0;
    entry_slot_d = entry_slot_q;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (exit_req) begin
          exit_ack_d = 1'b1;
          if (exit_hit) begin
            occ_d[exit_slot] = 1'b0;
            state_d          = StOpen;
            cnt_d            = CntW'(GATE_CYCLES - 1);
          end else begin
            exit_err_d = 1'b1;
          end
        end else if (entry_req) begin
          entry_ack_d = 1'b1;
          if (all_full) begin
            entry_full_d = 1'b1;
          end else begin
            occ_d[free_idx] = 1'b1;
            entry_slot_d    = free_idx;
            state_d         = StOpen;
            cnt_d           = CntW'(GATE_CYCLES - 1);
          end
        end
      end
      StOpen: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      occ_q        <= '0;
      entry_ack_q  <= 1'b0;
      entry_full_q <= 1'b0;
      entry_slot_q <= '0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      entry_ack_q  <= entry_ack_d;
      entry_full_q <= entry_full_d;
      entry_slot_q <= entry_slot_d;
      exit_ack_q   <= exit_ack_d;
      exit_err_q   <= exit_err_d;
    end
  end

  assign entry_ack  = entry_ack_q;
  assign entry_full = entry_full_q;
  assign entry_slot = entry_slot_q;
  assign exit_ack   = exit_ack_q;
  assign exit_err   = exit_err_q;
  assign occupancy  = occ_q;
  // The gate is open exactly while the state register holds StOpen.
  assign gate_open  = (state_q == StOpen);

`ifdef PARK_STATS_EN
  logic [7:0] entry_cnt_q, reject_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else begin
      if (entry_ack_d && !entry_full_d && entry_cnt_q != 8'hFF) begin
        entry_cnt_q <= entry_cnt_q + 8'd1;
      end
      if (entry_full_d && reject_cnt_q != 8'hFF) begin
        reject_cnt_q <= reject_cnt_q + 8'd1;
      end
    end
  end

  assign entry_count  = entry_cnt_q;
  assign reject_count = reject_cnt_q;
`endif

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Scoreboard bench for parking_slot_allocator (4 slots, 8-cycle gate).
module tb_parking_slot_allocator;

  localparam int unsigned NSlots = 4;
  localparam int unsigned SlotW  = 2;
  localparam int unsigned Gate   = 8;

  typedef struct {
    bit              is_exit;
    bit              flag;
    logic [SlotW-1:0] slot;
    logic [NSlots-1:0] occ;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              entry_req, exit_req;
  logic [SlotW-1:0]  exit_slot;
  logic              entry_ack, entry_full, exit_ack, exit_err, gate_open;
  logic [SlotW-1:0]  entry_slot;
  logic [NSlots-1:0] occupancy;
`ifdef PARK_STATS_EN
  logic [7:0]        entry_count, reject_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  parking_slot_allocator #(
    .NUM_SLOTS   (NSlots),
    .SLOT_W      (SlotW),
    .GATE_CYCLES (Gate)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entry_req    (entry_req),
    .entry_ack    (entry_ack),
    .entry_full   (entry_full),
    .entry_slot   (entry_slot),
    .exit_req     (exit_req),
    .exit_slot    (exit_slot),
    .exit_ack     (exit_ack),
    .exit_err     (exit_err),
    .gate_open    (gate_open),
`ifdef PARK_STATS_EN
    .entry_count  (entry_count),
    .reject_count (reject_count),
`endif
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_exit, input bit flag, input logic [SlotW-1:0] slot,
                          input logic [NSlots-1:0] occ);
    exp_t e;
    e.is_exit = is_exit;
    e.flag    = flag;
    e.slot    = slot;
    e.occ     = occ;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next ack and compares it against the scoreboard head.
  task automatic wait_ack();
    int   n = 0;
    exp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (!entry_ack && !exit_ack && n < 50);
    if (!entry_ack && !exit_ack) begin
      check_eq("ack_timeout", 32'(0), 32'(1));
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check_eq("unexpected_ack", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check_eq("ack_kind", 32'(exit_ack), 32'(e.is_exit));
      if (e.is_exit) check_eq("exit_err", 32'(exit_err), 32'(e.flag));
      else check_eq("entry_full", 32'(entry_full), 32'(e.flag));
      if (!e.is_exit && !e.flag) check_eq("entry_slot", 32'(entry_slot), 32'(e.slot));
      check_eq("occupancy", 32'(occupancy), 32'(e.occ));
      check_eq("gate_at_ack", 32'(gate_open), 32'(!e.flag));
    end
  endtask

  // Counts consecutive open cycles starting at the ack cycle.
  task automatic check_gate();
    int n = 0;
    while (gate_open && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("gate_len", 32'(n), 32'(Gate));
  endtask

  task automatic do_entry(input bit full, input logic [SlotW-1:0] slot,
                          input logic [NSlots-1:0] occ);
    push_exp(1'b0, full, slot, occ);
    entry_req = 1'b1;
    wait_ack();
    entry_req = 1'b0;
    if (!full) check_gate();
    else begin
      @(negedge clk);
      check_eq("gate_after_full", 32'(gate_open), 32'(0));
    end
  endtask

  task automatic do_exit(input logic [SlotW-1:0] slot, input bit err,
                         input logic [NSlots-1:0] occ);
    push_exp(1'b1, err, '0, occ);
    exit_slot = slot;
    exit_req  = 1'b1;
    wait_ack();
    exit_req = 1'b0;
    if (!err) check_gate();
    else begin
      @(negedge clk);
      check_eq("gate_after_err", 32'(gate_open), 32'(0));
      check_eq("occ_after_err", 32'(occupancy), 32'(occ));
    end
  endtask

  initial begin
    int t0, t1, acks;
    rst_n     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = '0;
    #1;
    check_eq("rst_occ", 32'(occupancy), 32'(0));
    check_eq("rst_gate", 32'(gate_open), 32'(0));
    check_eq("rst_acks", 32'({entry_ack, exit_ack, entry_full, exit_err}), 32'(0));
    check_eq("rst_slot", 32'(entry_slot), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill all slots in order.
    do_entry(1'b0, 2'd0, 4'b0001);
    do_entry(1'b0, 2'd1, 4'b0011);
    do_entry(1'b0, 2'd2, 4'b0111);
    do_entry(1'b0, 2'd3, 4'b1111);

    // Full rejection.
    do_entry(1'b1, 2'd0, 4'b1111);
`ifdef PARK_STATS_EN
    check_eq("reject_count", 32'(reject_count), 32'(1));
    check_eq("entry_count", 32'(entry_count), 32'(4));
`endif

    // Free slot 2 and reuse it.
    do_exit(2'd2, 1'b0, 4'b1011);
    do_entry(1'b0, 2'd2, 4'b1111);

    // Back down to a single occupied slot.
    do_exit(2'd3, 1'b0, 4'b0111);
    do_exit(2'd2, 1'b0, 4'b0011);
    do_exit(2'd1, 1'b0, 4'b0001);

    // Simultaneous requests: exit wins, entry follows after the gate cycle.
    push_exp(1'b1, 1'b0, '0, 4'b0000);
    push_exp(1'b0, 1'b0, 2'd0, 4'b0001);
    exit_slot = 2'd0;
    exit_req  = 1'b1;
    entry_req = 1'b1;
    wait_ack();
    exit_req = 1'b0;
    t0 = cyc;
    check_gate();
    wait_ack();
    entry_req = 1'b0;
    t1 = cyc;
    check_eq("prio_gap", 32'(t1 - t0), 32'(9));
    check_gate();

    // Exit of an empty slot is rejected.
    do_exit(2'd3, 1'b1, 4'b0001);

    // Reset in the third open cycle with an exit pending.
    push_exp(1'b0, 1'b0, 2'd1, 4'b0011);
    entry_req = 1'b1;
    wait_ack();
    entry_req = 1'b0;
    exit_slot = 2'd1;
    exit_req  = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("gate_before_rst", 32'(gate_open), 32'(1));
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_gate", 32'(gate_open), 32'(0));
    check_eq("rst_mid_occ", 32'(occupancy), 32'(0));
    exit_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (entry_ack || exit_ack) acks++;
    end
    check_eq("post_rst_acks", 32'(acks), 32'(0));
    check_eq("sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
